// File: rtl/dual_issue_fetch_queue.sv
// dual_issue_fetch_queue: circular fetch buffer that presents the two oldest instructions to a
// dual decoder and pops one or two per cycle, with flush support and issue-width perf counters.
module dual_issue_fetch_queue #(
    parameter int els_p        = 4,
    parameter int data_width_p = 32,
    parameter int pc_width_p   = 22,
    parameter int ctr_width_p  = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enq_v_i,
    input  logic [data_width_p-1:0] enq_instr_i,
    input  logic [pc_width_p-1:0]   enq_pc_i,
    output logic                    enq_ready_o,
    input  logic                    flush_i,
    input  logic                    id_ready_i,
    input  logic                    single_issue_i,
    output logic [data_width_p-1:0] instr0_o,
    output logic [data_width_p-1:0] instr1_o,
    output logic [pc_width_p-1:0]   pc0_o,
    output logic                    v0_o,
    output logic                    v1_o,
    output logic [1:0]              issue_cnt_o,
    output logic [ctr_width_p-1:0]  single_ctr_o,
    output logic [ctr_width_p-1:0]  dual_ctr_o
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam logic [lg_els_lp:0] els_lp = (lg_els_lp+1)'(els_p);

    logic [data_width_p-1:0] instr_mem_q [els_p];
    logic [pc_width_p-1:0]   pc_mem_q    [els_p];
    logic [lg_els_lp-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1;
    logic [lg_els_lp:0]      count_q, count_d;
    logic [ctr_width_p-1:0]  single_ctr_q, dual_ctr_q;
    logic                    enq_fire;

    always_comb begin
        rd_ptr1     = rd_ptr_q + lg_els_lp'(1);
        enq_ready_o = count_q != els_lp;
        enq_fire    = enq_v_i & enq_ready_o & ~flush_i;
        instr0_o    = instr_mem_q[rd_ptr_q];
        instr1_o    = instr_mem_q[rd_ptr1];
        pc0_o       = pc_mem_q[rd_ptr_q];
        v0_o        = count_q != '0;
        // the all-ones PC wraps to 0 and still pairs, so the sum stays at pc width
        v1_o        = (count_q >= (lg_els_lp+1)'(2)) & (pc_mem_q[rd_ptr1] == pc0_o + pc_width_p'(1));
        issue_cnt_o = (~v0_o | ~id_ready_i | flush_i) ? 2'd0 : (v1_o & ~single_issue_i) ? 2'd2 : 2'd1;
        rd_ptr_d    = rd_ptr_q + lg_els_lp'(issue_cnt_o);
        wr_ptr_d    = wr_ptr_q + lg_els_lp'(enq_fire);
        count_d     = count_q + (lg_els_lp+1)'(enq_fire) - (lg_els_lp+1)'(issue_cnt_o);
        single_ctr_o = single_ctr_q;
        dual_ctr_o   = dual_ctr_q;
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            instr_mem_q[wr_ptr_q] <= enq_instr_i;
            pc_mem_q[wr_ptr_q]    <= enq_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            single_ctr_q <= '0;
            dual_ctr_q   <= '0;
        end else begin
            rd_ptr_q     <= flush_i ? '0 : rd_ptr_d;
            wr_ptr_q     <= flush_i ? '0 : wr_ptr_d;
            count_q      <= flush_i ? '0 : count_d;
            single_ctr_q <= single_ctr_q + ctr_width_p'(issue_cnt_o == 2'd1);
            dual_ctr_q   <= dual_ctr_q + ctr_width_p'(issue_cnt_o == 2'd2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (els_p >= 2 && (els_p & (els_p - 1)) == 0);
            assert (count_q <= els_lp);
            assert (!(enq_fire && count_q == els_lp));
        end
    end
endmodule
